// File: rtl/redmule_pkg.sv
// Shared types and constants for the RedMulE MX exponent packing path.
package redmule_pkg;

    localparam int unsigned MX_EXP_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2
    } mx_pack_state_e;

endpackage

// File: rtl/redmule_mx_beat_reg.sv
// Single-entry valid/ready output register carrying data plus byte strobe.
module redmule_mx_beat_reg #(
    parameter int unsigned DW = 512,
    parameter int unsigned SW = DW / 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic [SW-1:0] strb_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic [SW-1:0] strb_o,
    input  logic          ready_i,
    output logic          free_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic [SW-1:0] strb_q, strb_d;

    // Free when empty or draining this cycle, so a new load never bubbles.
    assign free_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        strb_d  = strb_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            strb_d  = strb_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign strb_o  = strb_q;

endmodule

// File: rtl/redmule_mx_exp_packer.sv
// Packs 8-bit MX shared exponents little-endian into DATAW_ALIGN-bit beats.
// Optional beat/exponent counters under `REDMULE_MX_EXP_CNT_EN.
module redmule_mx_exp_packer
    import redmule_pkg::*;
#(
    parameter int unsigned DATAW_ALIGN = 512,
    parameter int unsigned EXP_W       = MX_EXP_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     mx_enable_i,
    input  logic                     flush_i,
    input  logic                     exp_valid_i,
    output logic                     exp_ready_o,
    input  logic [EXP_W-1:0]         exp_data_i,
    output logic                     beat_valid_o,
    input  logic                     beat_ready_i,
    output logic [DATAW_ALIGN-1:0]   beat_data_o,
    output logic [DATAW_ALIGN/8-1:0] beat_strb_o,
`ifdef REDMULE_MX_EXP_CNT_EN
    output logic [15:0]              beat_cnt_o,
    output logic [19:0]              exp_cnt_o,
`endif
    output logic                     busy_o
);

    localparam int unsigned LANES = DATAW_ALIGN / 8;
    localparam int unsigned IDX_W = $clog2(LANES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);

    logic                              srst;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [LANES-1:0][EXP_W-1:0]       fill_q, fill_d, word_w;
    logic                              flush_pend_q, flush_pend_d;
    logic                              mx_enable_q;
    mx_pack_state_e                    state_q, state_d;

    logic                              flush_req, accept, word_done, flush_xfer, out_free;
    logic                              load;
    logic [LANES-1:0][EXP_W-1:0]       load_data;
    logic [LANES-1:0]                  load_strb, part_strb;

    assign srst      = rst_i || clear_i;
    assign flush_req = flush_i || (mx_enable_q && !mx_enable_i);

    // A partial word waiting to flush blocks new bytes so it cannot grow.
    assign exp_ready_o = ((idx_q != LAST) || out_free) && !(flush_pend_q && (idx_q != '0));
    assign accept      = exp_valid_i && exp_ready_o;
    assign word_done   = accept && (idx_q == LAST);
    assign flush_xfer  = flush_pend_q && (idx_q != '0) && out_free;

    always_comb begin
        word_w        = fill_q;
        word_w[idx_q] = exp_data_i;
        part_strb     = '0;
        for (int k = 0; k < LANES; k++) part_strb[k] = (IDX_W'(k) < idx_q);
    end

    always_comb begin
        idx_d     = idx_q;
        fill_d    = fill_q;
        load      = 1'b0;
        load_data = fill_q;
        load_strb = '1;
        if (word_done) begin
            load   = 1'b1;
            load_data = word_w;
            idx_d  = '0;
            fill_d = '0;
        end else if (accept) begin
            fill_d = word_w;
            idx_d  = idx_q + 1'b1;
        end else if (flush_xfer) begin
            load      = 1'b1;
            load_strb = part_strb;
            idx_d     = '0;
            fill_d    = '0;
        end
        // Only a non-empty remainder needs a pending flush.
        flush_pend_d = (flush_pend_q || flush_req) && (idx_d != '0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = flush_req ? FLUSH : FILL;
            FILL:    if (word_done) state_d = IDLE;
                     else if (flush_req && (idx_d != '0)) state_d = FLUSH;
            FLUSH:   if (flush_xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst) begin
            idx_q        <= '0;
            fill_q       <= '0;
            flush_pend_q <= 1'b0;
            mx_enable_q  <= 1'b0;
            state_q      <= IDLE;
        end else begin
            idx_q        <= idx_d;
            fill_q       <= fill_d;
            flush_pend_q <= flush_pend_d;
            mx_enable_q  <= mx_enable_i;
            state_q      <= state_d;
        end
    end

    redmule_mx_beat_reg #(
        .DW (DATAW_ALIGN),
        .SW (LANES)
    ) i_beat_reg (
        .clk_i   (clk_i),
        .rst_i   (srst),
        .load_i  (load),
        .data_i  (load_data),
        .strb_i  (load_strb),
        .valid_o (beat_valid_o),
        .data_o  (beat_data_o),
        .strb_o  (beat_strb_o),
        .ready_i (beat_ready_i),
        .free_o  (out_free)
    );

    assign busy_o = (idx_q != '0) || beat_valid_o || flush_pend_q;

`ifdef REDMULE_MX_EXP_CNT_EN
    logic [15:0] beat_cnt_q, beat_cnt_d;
    logic [19:0] exp_cnt_q, exp_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        exp_cnt_d  = exp_cnt_q;
        if (beat_valid_o && beat_ready_i && (beat_cnt_q != '1)) beat_cnt_d = beat_cnt_q + 16'd1;
        if (accept && (exp_cnt_q != '1)) exp_cnt_d = exp_cnt_q + 20'd1;
    end

    always_ff @(posedge clk_i) begin
        if (srst) begin
            beat_cnt_q <= '0;
            exp_cnt_q  <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            exp_cnt_q  <= exp_cnt_d;
        end
    end

    assign beat_cnt_o = beat_cnt_q;
    assign exp_cnt_o  = exp_cnt_q;
`endif

endmodule

// File: tb/tb_redmule_mx_exp_packer.sv
// Directed bench for redmule_mx_exp_packer with a byte-queue beat model.
module tb_redmule_mx_exp_packer;

    localparam int DW    = 512;
    localparam int LANES = DW / 8;

    logic            clk_i = 1'b0;
    logic            rst_i, clear_i, mx_enable_i, flush_i;
    logic            exp_valid_i, exp_ready_o;
    logic [7:0]      exp_data_i;
    logic            beat_valid_o, beat_ready_i;
    logic [DW-1:0]   beat_data_o;
    logic [LANES-1:0] beat_strb_o;
    logic            busy_o;
`ifdef REDMULE_MX_EXP_CNT_EN
    logic [15:0]     beat_cnt_o;
    logic [19:0]     exp_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    redmule_mx_exp_packer #(.DATAW_ALIGN(DW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .mx_enable_i  (mx_enable_i),
        .flush_i      (flush_i),
        .exp_valid_i  (exp_valid_i),
        .exp_ready_o  (exp_ready_o),
        .exp_data_i   (exp_data_i),
        .beat_valid_o (beat_valid_o),
        .beat_ready_i (beat_ready_i),
        .beat_data_o  (beat_data_o),
        .beat_strb_o  (beat_strb_o),
`ifdef REDMULE_MX_EXP_CNT_EN
        .beat_cnt_o   (beat_cnt_o),
        .exp_cnt_o    (exp_cnt_o),
`endif
        .busy_o       (busy_o)
    );

    typedef struct {
        logic [DW-1:0]    data;
        logic [LANES-1:0] strb;
    } beat_t;

    int n_cmp = 0;
    int n_err = 0;
    int n_beats = 0;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Model: bytes accumulate in order; a beat is due at LANES bytes or on a
    // flush request with a non-empty remainder (same-cycle byte included).
    logic [7:0]       pend[$];
    beat_t            expq[$];
    logic             prev_en = 1'b0;
    logic             hold_v = 1'b0;
    logic [DW-1:0]    hold_d;
    logic [LANES-1:0] hold_s;

    function automatic beat_t mk_beat(input logic [7:0] q[$]);
        beat_t b;
        b.data = '0;
        b.strb = '0;
        for (int k = 0; k < q.size(); k++) begin
            b.data[8*k +: 8] = q[k];
            b.strb[k]        = 1'b1;
        end
        return b;
    endfunction

    always @(negedge clk_i) begin
        if (rst_i || clear_i) begin
            pend.delete();
            expq.delete();
            prev_en = 1'b0;
            hold_v  = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_data", beat_data_o, hold_d);
                chk("hold_strb", DW'(beat_strb_o), DW'(hold_s));
            end
            hold_v = beat_valid_o && !beat_ready_i;
            hold_d = beat_data_o;
            hold_s = beat_strb_o;
            if (beat_valid_o && beat_ready_i) begin
                n_beats++;
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_beat: got data %h want no beat", beat_data_o);
                end else begin
                    beat_t e;
                    e = expq.pop_front();
                    chk("beat_data", beat_data_o, e.data);
                    chk("beat_strb", DW'(beat_strb_o), DW'(e.strb));
                end
            end
            if (exp_valid_i && exp_ready_o) begin
                pend.push_back(exp_data_i);
                if (pend.size() == LANES) begin
                    expq.push_back(mk_beat(pend));
                    pend.delete();
                end
            end
            if ((flush_i || (prev_en && !mx_enable_i)) && pend.size() > 0) begin
                expq.push_back(mk_beat(pend));
                pend.delete();
            end
            prev_en = mx_enable_i;
        end
    end

    task automatic push(input logic [7:0] d, input logic fl);
        int t = 0;
        exp_valid_i = 1'b1;
        exp_data_i  = d;
        flush_i     = fl;
        @(negedge clk_i);
        while (!exp_ready_o && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 500) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: got exp_ready_o=0 for %0d cycles want 1", t);
        end
        @(posedge clk_i);
        #1;
        exp_valid_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_signal(input string name, input bit want_busy_low);
        int t = 0;
        @(negedge clk_i);
        while ((want_busy_low ? busy_o : !beat_valid_o) && t < 300) begin
            @(negedge clk_i);
            t++;
        end
        n_cmp++;
        if (t >= 300) begin
            n_err++;
            $display("FAIL %s: got timeout after %0d cycles want event", name, t);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_valid"}, DW'(beat_valid_o), '0);
        chk({tag, "_data"},  beat_data_o, '0);
        chk({tag, "_strb"},  DW'(beat_strb_o), '0);
        chk({tag, "_busy"},  DW'(busy_o), '0);
        chk({tag, "_ready"}, DW'(exp_ready_o), DW'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_i = 1'b1; clear_i = 1'b0; mx_enable_i = 1'b0; flush_i = 1'b0;
        exp_valid_i = 1'b0; exp_data_i = '0; beat_ready_i = 1'b1;
        idle(2);
        chk_reset_outs("rst0");
        rst_i = 1'b0;
        idle(1);

        // one full beat, byte k = k, visible the cycle after the last accept
        for (int k = 0; k < 63; k++) push(8'(k), 1'b0);
        chk("t1_no_early", DW'(beat_valid_o), '0);
        push(8'd63, 1'b0);
        chk("t1_valid", DW'(beat_valid_o), DW'(1));
        chk("t1_lo", DW'(beat_data_o[63:0]), DW'(64'h0706050403020100));
        chk("t1_hi", DW'(beat_data_o[511:448]), DW'(64'h3f3e3d3c3b3a3938));
        chk("t1_strb", DW'(beat_strb_o), DW'(64'hFFFF_FFFF_FFFF_FFFF));
        idle(3);

        // backpressure: stall at lane 63 with a full output register
        beat_ready_i = 1'b0;
        fork
            for (int k = 0; k < 130; k++) push(8'(k), 1'b0);
            begin
                idle(150);
                chk("t2_stall_ready", DW'(exp_ready_o), '0);
                chk("t2_stall_busy", DW'(busy_o), DW'(1));
                chk("t2_stall_valid", DW'(beat_valid_o), DW'(1));
                chk("t2_stall_b0", DW'(beat_data_o[7:0]), '0);
                beat_ready_i = 1'b1;
            end
        join
        push(8'd0, 1'b1);
        wait_signal("t2_drain", 1'b1);
        idle(2);

        // partial flush via mx_enable falling edge
        mx_enable_i = 1'b1;
        idle(1);
        for (int k = 0; k < 5; k++) push(8'hA1 + 8'(k), 1'b0);
        mx_enable_i = 1'b0;
        wait_signal("t3_wait", 1'b0);
        chk("t3_data", beat_data_o, DW'(40'hA5A4A3A2A1));
        chk("t3_strb", DW'(beat_strb_o), DW'(8'h1F));
        idle(3);

        // flush coincident with the 64th accept: exactly one beat
        base = n_beats;
        for (int k = 0; k < 63; k++) push(8'h40 + 8'(k), 1'b0);
        push(8'h7F, 1'b1);
        idle(10);
        chk("t4_one_beat", DW'(n_beats - base), DW'(1));

        // empty flush: nothing happens
        flush_i = 1'b1;
        idle(1);
        flush_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            chk("t5_busy", DW'(busy_o), '0);
            chk("t5_valid", DW'(beat_valid_o), '0);
        end
        idle(1);

        // reset in the middle of a beat
        for (int k = 0; k < 10; k++) push(8'h11 + 8'(k), 1'b0);
        rst_i = 1'b1;
        idle(1);
        chk_reset_outs("t6_rst");
        rst_i = 1'b0;
        for (int k = 0; k < 64; k++) push(8'h80 + 8'(k), 1'b0);
        chk("t6_valid", DW'(beat_valid_o), DW'(1));
        chk("t6_b0", DW'(beat_data_o[7:0]), DW'(8'h80));
        chk("t6_b63", DW'(beat_data_o[511:504]), DW'(8'hBF));
        idle(5);

        chk("end_queue", DW'(expq.size()), '0);
        chk("end_busy", DW'(busy_o), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
